// File: rtl/ysyx_22040729_opsel_pkg.sv
// Shared encodings for the operand-select stage: source selects, occupancy states
// and the constant used for PC+4 style operands.
package ysyx_22040729_pkg;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;

    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_C4   = 2'd2;

    localparam int CONST4 = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/ysyx_22040729_opsel_entry.sv
// One held operand-select entry. Whatever is loaded or held gets the writeback
// forward applied on the way into the flops, so captured and stalled data stay current.
module ysyx_22040729_opsel_entry
    import ysyx_22040729_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] ld_pc,
    input  logic [DATA_WIDTH-1:0] ld_rs1_data,
    input  logic [DATA_WIDTH-1:0] ld_rs2_data,
    input  logic [DATA_WIDTH-1:0] ld_imm,
    input  logic [REG_IDX_W-1:0]  ld_rs1_idx,
    input  logic [REG_IDX_W-1:0]  ld_rs2_idx,
    input  logic [1:0]            ld_src1_sel,
    input  logic [1:0]            ld_src2_sel,
    input  logic                  fwd_wen,
    input  logic [REG_IDX_W-1:0]  fwd_idx,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [REG_IDX_W-1:0]  rs1_idx,
    output logic [REG_IDX_W-1:0]  rs2_idx,
    output logic [1:0]            src1_sel,
    output logic [1:0]            src2_sel
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [REG_IDX_W-1:0]  rs1_idx_q, rs1_idx_d;
    logic [REG_IDX_W-1:0]  rs2_idx_q, rs2_idx_d;
    logic [1:0]            src1_sel_q, src1_sel_d;
    logic [1:0]            src2_sel_q, src2_sel_d;

    always_comb begin
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_idx_d  = rs1_idx_q;
        rs2_idx_d  = rs2_idx_q;
        src1_sel_d = src1_sel_q;
        src2_sel_d = src2_sel_q;
        if (load) begin
            pc_d       = ld_pc;
            rs1_data_d = ld_rs1_data;
            rs2_data_d = ld_rs2_data;
            imm_d      = ld_imm;
            rs1_idx_d  = ld_rs1_idx;
            rs2_idx_d  = ld_rs2_idx;
            src1_sel_d = ld_src1_sel;
            src2_sel_d = ld_src2_sel;
        end
        // x0 is hardwired, so a write to it must never leak into an operand
        if (fwd_wen && (fwd_idx == rs1_idx_d) && (rs1_idx_d != '0)) rs1_data_d = fwd_data;
        if (fwd_wen && (fwd_idx == rs2_idx_d) && (rs2_idx_d != '0)) rs2_data_d = fwd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_idx_q  <= '0;
            rs2_idx_q  <= '0;
            src1_sel_q <= SRC1_RS1;
            src2_sel_q <= SRC2_RS2;
        end else begin
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_idx_q  <= rs1_idx_d;
            rs2_idx_q  <= rs2_idx_d;
            src1_sel_q <= src1_sel_d;
            src2_sel_q <= src2_sel_d;
        end
    end

    assign pc       = pc_q;
    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign imm      = imm_q;
    assign rs1_idx  = rs1_idx_q;
    assign rs2_idx  = rs2_idx_q;
    assign src1_sel = src1_sel_q;
    assign src2_sel = src2_sel_q;

endmodule

// File: rtl/ysyx_22040729_opsel.sv
// Operand-select stage ahead of the ALU: two-entry skid buffer (head + skid) with
// registered in_ready, writeback forwarding at capture and while held.
module ysyx_22040729_opsel
    import ysyx_22040729_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [REG_IDX_W-1:0]  in_rs1_idx,
    input  logic [REG_IDX_W-1:0]  in_rs2_idx,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [1:0]            in_src1_sel,
    input  logic [1:0]            in_src2_sel,
    input  logic                  fwd_wen,
    input  logic [REG_IDX_W-1:0]  fwd_idx,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2
);

    occ_e state_q, state_d;
    logic in_ready_q, in_ready_d;
    logic accept, consume;
    logic head_load, skid_load, head_from_skid;

    logic [DATA_WIDTH-1:0] h_pc, h_rs1_data, h_rs2_data, h_imm;
    logic [REG_IDX_W-1:0]  h_rs1_idx, h_rs2_idx;
    logic [1:0]            h_src1_sel, h_src2_sel;
    logic [DATA_WIDTH-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [REG_IDX_W-1:0]  s_rs1_idx, s_rs2_idx;
    logic [1:0]            s_src1_sel, s_src2_sel;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        accept         = in_valid && in_ready_q;
        consume        = (state_q != OCC_EMPTY) && out_ready;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d   = OCC_ONE;
                        head_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && !consume) begin
                        state_d   = OCC_TWO;
                        skid_load = 1'b1;
                    end else if (consume && !accept) begin
                        state_d = OCC_EMPTY;
                    end else if (consume && accept) begin
                        head_load = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (consume) begin
                        state_d        = OCC_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    ysyx_22040729_opsel_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_IDX_W  (REG_IDX_W)
    ) u_head (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (head_load),
        .ld_pc       (head_from_skid ? s_pc       : in_pc),
        .ld_rs1_data (head_from_skid ? s_rs1_data : in_rs1_data),
        .ld_rs2_data (head_from_skid ? s_rs2_data : in_rs2_data),
        .ld_imm      (head_from_skid ? s_imm      : in_imm),
        .ld_rs1_idx  (head_from_skid ? s_rs1_idx  : in_rs1_idx),
        .ld_rs2_idx  (head_from_skid ? s_rs2_idx  : in_rs2_idx),
        .ld_src1_sel (head_from_skid ? s_src1_sel : in_src1_sel),
        .ld_src2_sel (head_from_skid ? s_src2_sel : in_src2_sel),
        .fwd_wen     (fwd_wen),
        .fwd_idx     (fwd_idx),
        .fwd_data    (fwd_data),
        .pc          (h_pc),
        .rs1_data    (h_rs1_data),
        .rs2_data    (h_rs2_data),
        .imm         (h_imm),
        .rs1_idx     (h_rs1_idx),
        .rs2_idx     (h_rs2_idx),
        .src1_sel    (h_src1_sel),
        .src2_sel    (h_src2_sel)
    );

    ysyx_22040729_opsel_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_IDX_W  (REG_IDX_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (skid_load),
        .ld_pc       (in_pc),
        .ld_rs1_data (in_rs1_data),
        .ld_rs2_data (in_rs2_data),
        .ld_imm      (in_imm),
        .ld_rs1_idx  (in_rs1_idx),
        .ld_rs2_idx  (in_rs2_idx),
        .ld_src1_sel (in_src1_sel),
        .ld_src2_sel (in_src2_sel),
        .fwd_wen     (fwd_wen),
        .fwd_idx     (fwd_idx),
        .fwd_data    (fwd_data),
        .pc          (s_pc),
        .rs1_data    (s_rs1_data),
        .rs2_data    (s_rs2_data),
        .imm         (s_imm),
        .rs1_idx     (s_rs1_idx),
        .rs2_idx     (s_rs2_idx),
        .src1_sel    (s_src1_sel),
        .src2_sel    (s_src2_sel)
    );

    // Only the head's fields are visible; the unused head indices exist for snooping.
    always_comb begin
        src1 = '0;
        src2 = '0;
        case (h_src1_sel)
            SRC1_RS1: src1 = h_rs1_data;
            SRC1_PC:  src1 = h_pc;
            default:  src1 = '0;
        endcase
        case (h_src2_sel)
            SRC2_RS2: src2 = h_rs2_data;
            SRC2_IMM: src2 = h_imm;
            SRC2_C4:  src2 = DATA_WIDTH'(CONST4);
            default:  src2 = '0;
        endcase
    end

    logic unused_idx;
    assign unused_idx = ^{h_rs1_idx, h_rs2_idx};

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_ready  = in_ready_q;

endmodule

// File: doc/ysyx_22040729_opsel.md
# ysyx_22040729_opsel

Operand-select stage directly upstream of the ALU: accepts decoded instructions from ID, resolves and holds both ALU source operands, and presents them as `src1`/`src2` to the ALU through a valid/ready handshake. It owns writeback forwarding, including snooping while operands are stalled. A two-entry skid buffer keeps `in_ready` registered, so ID never sees a combinational path from EX backpressure.

## Interface
- `DATA_WIDTH`, 64, operand/data width
- `REG_IDX_W`, 5, register index width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  discard all held entries (branch redirect)
- `in_valid`  in  1  ID presents an instruction
- `in_ready`  out  1  stage can accept; registered
- `in_pc`  in  DATA_WIDTH  instruction PC
- `in_rs1_data`, `in_rs2_data`  in  DATA_WIDTH  register-file read data
- `in_rs1_idx`, `in_rs2_idx`  in  REG_IDX_W  source register indices
- `in_imm`  in  DATA_WIDTH  sign-extended immediate
- `in_src1_sel`  in  2  0 = RS1, 1 = PC, 2 = ZERO, 3 = reserved (treated as ZERO)
- `in_src2_sel`  in  2  0 = RS2, 1 = IMM, 2 = CONST4, 3 = reserved (treated as ZERO)
- `fwd_wen`  in  1  writeback writes a register this cycle
- `fwd_idx`  in  REG_IDX_W  writeback destination
- `fwd_data`  in  DATA_WIDTH  writeback value
- `out_valid`  out  1  `src1`/`src2` valid
- `out_ready`  in  1  ALU/EX consumes this cycle
- `src1`, `src2`  out  DATA_WIDTH  ALU operands

## Operation
- Each entry stores: pc, rs1/rs2 data, rs1/rs2 idx, imm, both selects. Output operands are muxed combinationally from the head entry.
- Forwarding at capture: if `fwd_wen && fwd_idx == in_rsX_idx && in_rsX_idx != 0`, store `fwd_data` instead of `in_rsX_data`.
- Snooping: every held entry with a matching non-zero index overwrites its stored rsX data with `fwd_data` each cycle `fwd_wen` is high. This keeps stalled operands current.
- Index 0 is never forwarded and always reads as the value stored at capture.
- State machine on occupancy:
  - EMPTY: `in_ready` = 1.
  - ONE: head valid, `in_ready` = 1.
  - TWO: head and skid valid, `in_ready` = 0.
- Accept = `in_valid && in_ready`. Consume = `out_valid && out_ready`.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE: accept without consume → TWO; consume without accept → EMPTY; both → ONE, with the new entry becoming head.
  - TWO: consume → ONE, skid moves to head. No accept is possible in TWO.
- FIFO order is strict. The head is always the oldest entry.
- `flush` has priority over everything. Next state is EMPTY, any accept or consume in the same cycle is discarded, and both entries are invalidated.
- `out_valid` = state != EMPTY.

## Timing
- Reset (async assert, sync-safe deassert by the top): state EMPTY, `out_valid` = 0, `in_ready` = 1, stored fields 0, so `src1` = `src2` = 0.
- Latency: an entry accepted in cycle N is visible on `out_valid`/`src*` in cycle N+1.
- Throughput is one per cycle while `out_ready` stays high.
- `in_ready` is a flop output: it equals (next state != TWO), computed in the prior cycle.
- `src1`/`src2` may change while `out_valid` is high and the entry is unconsumed, but only through snoop updates. `pc`, `imm` and selects are stable.
- A forward in the same cycle as capture is applied. A forward in the same cycle as consume affects only entries that remain held.
- A flush in the same cycle as a reset deassert has no additional effect.

## Structure
- Shared package `ysyx_22040729_pkg`: `SRC1_RS1`, `SRC1_PC`, `SRC1_ZERO`, `SRC2_RS2`, `SRC2_IMM`, `SRC2_C4`, the occupancy state encodings, and the `CONST4` value.
- One sub-module, `ysyx_22040729_opsel_entry`, instantiated twice (head, skid). It holds one entry's registers and its snoop-update logic. Load and shift control come from the parent.

## Test plan
- Reset then idle: `out_valid` = 0, `in_ready` = 1, `src1` = `src2` = 0. Accept rs1 = 0x10, rs2 = 0x20, sel = 0/0 → next cycle `src1` = 0x10, `src2` = 0x20.
- Select decode: pc = 0x8000_0000, imm = -4, sel1 = PC, sel2 = IMM → `src1` = 0x8000_0000, `src2` = 0xFFFF_FFFF_FFFF_FFFC. Then sel2 = CONST4 → `src2` = 4.
- Forward at capture: `in_rs1_idx` = 5, `in_rs1_data` = 1, with `fwd_wen`, idx 5, data 0xAB in the same cycle → `src1` = 0xAB. Repeat with idx 0 → `src1` = 1.
- Backpressure: hold `out_ready` = 0 and push A, B → `in_ready` falls in the cycle after B is accepted. C waits until A is consumed; output order is A, B, C with no loss or duplication.
- Stall snoop: entry with rs2_idx = 7 held under `out_ready` = 0; forward idx 7, data 0x55 → `src2` = 0x55 the next cycle; consume → 0x55 delivered.
- Flush in TWO with `in_valid` and `out_ready` also high → next cycle `out_valid` = 0, `in_ready` = 1, and the input offered in the flush cycle is not accepted. Also assert `rst_n` mid-stream → immediate EMPTY.
